load_store_unit: RTL and testbench

Sits between the execute stage and data_memory. It converts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned memory accesses.
- Loads: extracts and extends bytes and halfwords.
- Sub-word stores: performed as a two-cycle read-modify-write, because data_memory only supports full-word writes.
- Misaligned accesses and illegal funct3 values are flagged and never touch memory.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_lane_align.sv | 74 +++++++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I funct3 access sizes and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } lsu_state_e;

  // Byte and halfword stores cannot be written directly and go through read-modify-write.
  function automatic logic is_sub_word(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction and extension for loads, lane merge for stores, and the
// legality check (size/alignment/funct3). Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic        i_is_store,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_val,
  output logic [31:0] o_store_word,
  output logic        o_legal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_load_val = '0;
    case (i_funct3)
      F3_B:    o_load_val = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_val = {24'h0, w_byte};
      F3_H:    o_load_val = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_val = {16'h0, w_half};
      F3_W:    o_load_val = i_word;
      default: o_load_val = '0;
    endcase
  end

  always_comb begin
    o_store_word = i_word;
    case (i_funct3)
      F3_B: begin
        case (i_addr_lo)
          2'd0:    o_store_word[7:0]   = i_wdata[7:0];
          2'd1:    o_store_word[15:8]  = i_wdata[7:0];
          2'd2:    o_store_word[23:16] = i_wdata[7:0];
          default: o_store_word[31:24] = i_wdata[7:0];
        endcase
      end
      F3_H: begin
        if (i_addr_lo[1]) o_store_word[31:16] = i_wdata[15:0];
        else              o_store_word[15:0]  = i_wdata[15:0];
      end
      default: o_store_word = i_wdata;
    endcase
  end

  // Unsigned variants exist only for loads.
  always_comb begin
    o_legal = 1'b0;
    case (i_funct3)
      F3_B:    o_legal = 1'b1;
      F3_BU:   o_legal = !i_is_store;
      F3_H:    o_legal = !i_addr_lo[0];
      F3_HU:   o_legal = !i_is_store && !i_addr_lo[0];
      F3_W:    o_legal = (i_addr_lo == 2'b00);
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store front end for a word-only data memory. Sub-word stores use a
// two-cycle read-modify-write; illegal or misaligned requests never reach memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  input  logic              i_req_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_misaligned,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic              r_resp_valid;
  logic              r_misaligned;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_rmw_addr;
  logic [DATA_W-1:0] r_rmw_wdata;

  logic [ADDR_W-1:0] w_addr_aligned;
  logic [DATA_W-1:0] w_load_val;
  logic [DATA_W-1:0] w_store_word;
  logic              w_legal;
  logic              w_accept;
  logic              w_sub_store;

  assign w_addr_aligned = {i_addr[ADDR_W-1:2], 2'b00};
  assign w_accept       = (r_state == ST_IDLE) && i_req_valid;
  assign w_sub_store    = i_req_we && is_sub_word(i_funct3);

  lsu_lane_align u_lane_align (
    .i_funct3     (i_funct3),
    .i_is_store   (i_req_we),
    .i_addr_lo    (i_addr[1:0]),
    .i_word       (i_mem_rdata),
    .i_wdata      (i_wdata),
    .o_load_val   (w_load_val),
    .o_store_word (w_store_word),
    .o_legal      (w_legal)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept && w_legal && w_sub_store) w_state_nxt = ST_RMW_WR;
      ST_RMW_WR: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Gated by reset so that every output reads zero while reset is held, even with a live request.
  always_comb begin
    o_busy      = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (i_rst_n) begin
      case (r_state)
        ST_IDLE: begin
          o_mem_addr = w_addr_aligned;
          if (w_accept && w_legal && i_req_we && !w_sub_store) begin
            o_mem_we    = 1'b1;
            o_mem_wdata = i_wdata;
          end
        end
        ST_RMW_WR: begin
          o_busy      = 1'b1;
          o_mem_we    = 1'b1;
          o_mem_addr  = r_rmw_addr;
          o_mem_wdata = r_rmw_wdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_resp_valid <= 1'b0;
      r_misaligned <= 1'b0;
      r_rdata      <= '0;
      r_rmw_addr   <= '0;
      r_rmw_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_misaligned <= 1'b0;
      if (r_state == ST_RMW_WR) begin
        r_resp_valid <= 1'b1;
      end else if (w_accept) begin
        if (!w_legal) begin
          r_resp_valid <= 1'b1;
          r_misaligned <= 1'b1;
        end else if (!i_req_we) begin
          r_resp_valid <= 1'b1;
          r_rdata      <= w_load_val;
        end else if (w_sub_store) begin
          r_rmw_addr  <= w_addr_aligned;
          r_rmw_wdata <= w_store_word;
        end else begin
          r_resp_valid <= 1'b1;
        end
      end
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_misaligned = r_misaligned;
  assign o_rdata      = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model and a response scoreboard.
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        i_req_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic        o_resp_valid;
  logic [31:0] o_rdata;
  logic        o_misaligned;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:15];
  logic [32:0] q [$];
  logic [31:0] hold_rdata;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 i_clk = ~i_clk;

  always_comb begin
    mem_rdata = 32'h0;
    if (o_mem_addr < 32'd64) mem_rdata = mem[o_mem_addr[5:2]];
  end

  always @(posedge i_clk)
    if (o_mem_we && o_mem_addr < 32'd64) mem[o_mem_addr[5:2]] <= o_mem_wdata;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .i_req_we     (i_req_we),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_busy       (o_busy),
    .o_resp_valid (o_resp_valid),
    .o_rdata      (o_rdata),
    .o_misaligned (o_misaligned),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Drives a request and queues its expected response; a legal load updates the held rdata.
  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic mis, input logic [31:0] ld);
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_funct3    = f3;
    i_addr      = addr;
    i_wdata     = wd;
    if (!we && !mis) hold_rdata = ld;
    q.push_back({mis, hold_rdata});
    #1;
  endtask

  task automatic idle();
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
    i_funct3    = 3'b000;
    i_wdata     = 32'h0;
  endtask

  task automatic expect_resp(input string tag);
    logic [32:0] e;
    chk({tag, ".valid"}, {31'h0, o_resp_valid}, 32'h1);
    n_tests++;
    assert (q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, ".mis"}, {31'h0, o_misaligned}, {31'h0, e[32]});
      chk({tag, ".rdata"}, o_rdata, e[31:0]);
    end
  endtask

  initial begin
    hold_rdata  = 32'h0;
    i_rst_n     = 1'b0;
    i_addr      = 32'h0;
    idle();
    #2;
    chk("rst.busy", {31'h0, o_busy}, 32'h0);
    chk("rst.resp", {31'h0, o_resp_valid}, 32'h0);
    chk("rst.rdata", o_rdata, 32'h0);
    chk("rst.mis", {31'h0, o_misaligned}, 32'h0);
    chk("rst.we", {31'h0, o_mem_we}, 32'h0);
    chk("rst.addr", o_mem_addr, 32'h0);
    chk("rst.wdata", o_mem_wdata, 32'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();

    // Preload memory through full-word stores
    drive(1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0);
    chk("pre0.we", {31'h0, o_mem_we}, 32'h1);
    step(); idle(); expect_resp("pre0");
    drive(1'b1, 3'b010, 32'h04, 32'h11223344, 1'b0, 32'h0);
    step(); idle(); expect_resp("pre1");
    chk("pre.mem2", mem[2], 32'hDEADBEEF);

    // Loads, back-to-back
    drive(1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hDEADBEEF);
    chk("lw.addr", o_mem_addr, 32'h08);
    chk("lw.we", {31'h0, o_mem_we}, 32'h0);
    step(); expect_resp("lw");
    drive(1'b0, 3'b000, 32'h09, 32'h0, 1'b0, 32'hFFFFFFBE);
    chk("lb.addr", o_mem_addr, 32'h08);
    step(); expect_resp("lb");
    drive(1'b0, 3'b100, 32'h09, 32'h0, 1'b0, 32'h000000BE);
    step(); expect_resp("lbu");
    drive(1'b0, 3'b001, 32'h0A, 32'h0, 1'b0, 32'hFFFFDEAD);
    step(); expect_resp("lh");
    drive(1'b0, 3'b101, 32'h0A, 32'h0, 1'b0, 32'h0000DEAD);
    step(); idle(); expect_resp("lhu");
    step();
    chk("pulse.resp", {31'h0, o_resp_valid}, 32'h0);
    chk("hold.rdata", o_rdata, 32'h0000DEAD);

    // SB with a load held while busy
    drive(1'b1, 3'b000, 32'h0B, 32'h12345678, 1'b0, 32'h0);
    chk("sb.idle_we", {31'h0, o_mem_we}, 32'h0);
    step();
    drive(1'b0, 3'b010, 32'h04, 32'h0, 1'b0, 32'h11223344);
    chk("sb.busy", {31'h0, o_busy}, 32'h1);
    chk("sb.we", {31'h0, o_mem_we}, 32'h1);
    chk("sb.addr", o_mem_addr, 32'h08);
    chk("sb.wdata", o_mem_wdata, 32'h78ADBEEF);
    chk("sb.noresp", {31'h0, o_resp_valid}, 32'h0);
    step();
    expect_resp("sb");
    chk("held.busy", {31'h0, o_busy}, 32'h0);
    chk("held.addr", o_mem_addr, 32'h04);
    chk("held.we", {31'h0, o_mem_we}, 32'h0);
    chk("sb.mem", mem[2], 32'h78ADBEEF);
    step(); idle(); expect_resp("held_lw");

    // SH then SW
    drive(1'b1, 3'b001, 32'h08, 32'h0000CAFE, 1'b0, 32'h0);
    step(); idle();
    chk("sh.busy", {31'h0, o_busy}, 32'h1);
    chk("sh.wdata", o_mem_wdata, 32'h78ADCAFE);
    step(); expect_resp("sh");
    chk("sh.mem", mem[2], 32'h78ADCAFE);
    drive(1'b1, 3'b010, 32'h0C, 32'hA5A5A5A5, 1'b0, 32'h0);
    chk("sw.we", {31'h0, o_mem_we}, 32'h1);
    chk("sw.wdata", o_mem_wdata, 32'hA5A5A5A5);
    chk("sw.busy", {31'h0, o_busy}, 32'h0);
    step(); idle(); expect_resp("sw");
    chk("sw.busy_after", {31'h0, o_busy}, 32'h0);
    chk("sw.mem", mem[3], 32'hA5A5A5A5);

    // Rejected requests
    drive(1'b0, 3'b010, 32'h06, 32'h0, 1'b1, 32'h0);
    chk("lw06.we", {31'h0, o_mem_we}, 32'h0);
    step(); expect_resp("lw06");
    drive(1'b1, 3'b001, 32'h09, 32'hFFFFFFFF, 1'b1, 32'h0);
    chk("sh09.we", {31'h0, o_mem_we}, 32'h0);
    chk("sh09.wdata", o_mem_wdata, 32'h0);
    step(); expect_resp("sh09");
    chk("sh09.busy", {31'h0, o_busy}, 32'h0);
    drive(1'b0, 3'b011, 32'h00, 32'h0, 1'b1, 32'h0);
    step(); expect_resp("f3_011");
    drive(1'b1, 3'b100, 32'h08, 32'h000000FF, 1'b1, 32'h0);
    chk("sbu.we", {31'h0, o_mem_we}, 32'h0);
    step(); expect_resp("sbu");
    drive(1'b0, 3'b010, 32'h0C, 32'h0, 1'b0, 32'hA5A5A5A5);
    step(); idle(); expect_resp("lw0c");
    chk("rej.mem2", mem[2], 32'h78ADCAFE);

    // Restore word, then reset in the middle of an RMW
    drive(1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0);
    step(); idle(); expect_resp("restore");
    drive(1'b1, 3'b000, 32'h08, 32'h000000FF, 1'b0, 32'h0);
    step();
    chk("rmw.busy", {31'h0, o_busy}, 32'h1);
    #2;
    i_rst_n = 1'b0;
    q.delete();
    hold_rdata = 32'h0;
    #1;
    chk("mrst.busy", {31'h0, o_busy}, 32'h0);
    chk("mrst.we", {31'h0, o_mem_we}, 32'h0);
    chk("mrst.addr", o_mem_addr, 32'h0);
    chk("mrst.wdata", o_mem_wdata, 32'h0);
    chk("mrst.rdata", o_rdata, 32'h0);
    chk("mrst.resp", {31'h0, o_resp_valid}, 32'h0);
    idle();
    step();
    chk("mrst.mem", mem[2], 32'hDEADBEEF);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
    chk("post.busy", {31'h0, o_busy}, 32'h0);
    drive(1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hDEADBEEF);
    step(); idle(); expect_resp("post_lw");
    step();
    chk("q.empty", q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
